// File: rtl/if_stage_pkg.sv
// Shared constants and helpers for the instruction-fetch stage.
// Bus widths, reset level, NOP encoding and ctrl stall-vector bit indices.
package if_stage_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    localparam logic                   RstEnable = 1'b1;
    localparam logic [InstAddrBus-1:0] ZeroWord  = 32'h0000_0000;
    localparam logic [InstBus-1:0]     NOP       = 32'h0000_0000;

    localparam int STALL_PC = 0;
    localparam int STALL_IF = 1;
    localparam int STALL_ID = 2;

    // Instruction addresses are word aligned; low two bits are forced to zero.
    function automatic logic [InstAddrBus-1:0] word_align(input logic [InstAddrBus-1:0] addr);
        return {addr[InstAddrBus-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_pc_reg.sv
// Program counter with ROM chip enable and the redirect/stall priority mux.
// The PC only moves once the chip enable is up, one cycle after reset release.
module pc_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_pc,
    input  logic                   flush,
    input  logic [InstAddrBus-1:0] new_pc,
    input  logic                   branch_flag,
    input  logic [InstAddrBus-1:0] branch_target,
    input  logic                   inst_ready,
    output logic [InstAddrBus-1:0] pc,
    output logic                   ce
);

    logic [InstAddrBus-1:0] pc_r;
    logic [InstAddrBus-1:0] pc_next_s;
    logic                   ce_r;

    // Next-PC selection; a stalled PC drops the branch since decode re-presents it.
    always_comb begin
        pc_next_s = pc_r;
        if (!ce_r) begin
            pc_next_s = pc_r;
        end else if (flush) begin
            pc_next_s = word_align(new_pc);
        end else if (stall_pc) begin
            pc_next_s = pc_r;
        end else if (branch_flag) begin
            pc_next_s = word_align(branch_target);
        end else if (!inst_ready) begin
            pc_next_s = pc_r;
        end else begin
            pc_next_s = pc_r + 32'd4;
        end
    end

    // PC and chip-enable registers.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            pc_r <= word_align(RESET_PC);
            ce_r <= 1'b0;
        end else begin
            pc_r <= pc_next_s;
            ce_r <= 1'b1;
        end
    end

    assign pc = pc_r;
    assign ce = ce_r;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC/ROM request via pc_reg, ROM wait stall request
// and the IF/ID pipeline register feeding decode.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [5:0]             stall_i,
    input  logic                   flush_i,
    input  logic [InstAddrBus-1:0] new_pc_i,
    input  logic                   branch_flag_i,
    input  logic [InstAddrBus-1:0] branch_target_i,
    input  logic [InstBus-1:0]     inst_i,
    input  logic                   inst_ready_i,
    output logic [InstAddrBus-1:0] inst_addr_o,
    output logic                   inst_ce_o,
    output logic                   stallreq_if_o,
    output logic [InstAddrBus-1:0] id_pc_o,
    output logic [InstBus-1:0]     id_inst_o
);

    logic [InstAddrBus-1:0] pc_s;
    logic                   ce_s;
    logic                   fetch_ok_s;
    logic [InstAddrBus-1:0] id_pc_r;
    logic [InstBus-1:0]     id_inst_r;
    logic [InstAddrBus-1:0] id_pc_next_s;
    logic [InstBus-1:0]     id_inst_next_s;

    pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk          (clk),
        .rst          (rst),
        .stall_pc     (stall_i[STALL_PC]),
        .flush        (flush_i),
        .new_pc       (new_pc_i),
        .branch_flag  (branch_flag_i),
        .branch_target(branch_target_i),
        .inst_ready   (inst_ready_i),
        .pc           (pc_s),
        .ce           (ce_s)
    );

    // A fetch only counts when the ROM was actually enabled for this address.
    assign fetch_ok_s    = ce_s & inst_ready_i;
    assign stallreq_if_o = ce_s & ~inst_ready_i & ~rst;

    // IF/ID next value: flush, bubble on IF-only stall, hold on IF+ID stall, bubble on ROM wait.
    always_comb begin
        id_pc_next_s   = id_pc_r;
        id_inst_next_s = id_inst_r;
        if (flush_i) begin
            id_pc_next_s   = ZeroWord;
            id_inst_next_s = NOP;
        end else if (stall_i[STALL_IF] && !stall_i[STALL_ID]) begin
            id_pc_next_s   = ZeroWord;
            id_inst_next_s = NOP;
        end else if (stall_i[STALL_IF]) begin
            id_pc_next_s   = id_pc_r;
            id_inst_next_s = id_inst_r;
        end else if (!fetch_ok_s) begin
            id_pc_next_s   = ZeroWord;
            id_inst_next_s = NOP;
        end else begin
            id_pc_next_s   = pc_s;
            id_inst_next_s = inst_i;
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            id_pc_r   <= ZeroWord;
            id_inst_r <= NOP;
        end else begin
            id_pc_r   <= id_pc_next_s;
            id_inst_r <= id_inst_next_s;
        end
    end

    assign inst_addr_o = pc_s;
    assign inst_ce_o   = ce_s;
    assign id_pc_o     = id_pc_r;
    assign id_inst_o   = id_inst_r;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus a randomized run,
// all checked against a cycle-level reference model of fetch and IF/ID behaviour.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic [31:0] new_pc_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic [31:0] inst_i;
    logic        inst_ready_i;
    logic [31:0] inst_addr_o;
    logic        inst_ce_o;
    logic        stallreq_if_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic        m_ce;
    logic [31:0] m_id_pc;
    logic [31:0] m_id_inst;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .new_pc_i       (new_pc_i),
        .branch_flag_i  (branch_flag_i),
        .branch_target_i(branch_target_i),
        .inst_i         (inst_i),
        .inst_ready_i   (inst_ready_i),
        .inst_addr_o    (inst_addr_o),
        .inst_ce_o      (inst_ce_o),
        .stallreq_if_o  (stallreq_if_o),
        .id_pc_o        (id_pc_o),
        .id_inst_o      (id_inst_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'hC0DE_0001;
    endfunction

    // Advance one clock: compute the expected next state from the spec rules, then update.
    task automatic step();
        logic [31:0] npc, nid_pc, nid_inst;
        logic        nce, fetched;
        if (rst) begin
            npc = 32'd0; nce = 1'b0; nid_pc = 32'd0; nid_inst = 32'd0;
        end else begin
            nce = 1'b1;
            if (!m_ce)                npc = m_pc;
            else if (flush_i)         npc = (new_pc_i / 4) * 4;
            else if (stall_i[0])      npc = m_pc;
            else if (branch_flag_i)   npc = (branch_target_i / 4) * 4;
            else if (!inst_ready_i)   npc = m_pc;
            else                      npc = m_pc + 32'd4;
            fetched = m_ce && inst_ready_i;
            if (flush_i || (stall_i[1] && !stall_i[2])) begin
                nid_pc = 32'd0; nid_inst = 32'd0;
            end else if (stall_i[1]) begin
                nid_pc = m_id_pc; nid_inst = m_id_inst;
            end else if (!fetched) begin
                nid_pc = 32'd0; nid_inst = 32'd0;
            end else begin
                nid_pc = m_pc; nid_inst = inst_i;
            end
        end
        @(posedge clk);
        m_pc = npc; m_ce = nce; m_id_pc = nid_pc; m_id_inst = nid_inst;
        #1;
        inst_i = rom(m_pc);
        #1;
    endtask

    task automatic clear_inputs();
        stall_i = 6'd0; flush_i = 1'b0; new_pc_i = 32'd0;
        branch_flag_i = 1'b0; branch_target_i = 32'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1; inst_ready_i = 1'b1; inst_i = 32'd0; clear_inputs();
        m_pc = 32'd0; m_ce = 1'b0; m_id_pc = 32'd0; m_id_inst = 32'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({inst_addr_o, inst_ce_o, stallreq_if_o, id_pc_o, id_inst_o} !== {32'd0, 1'b0, 1'b0, 32'd0, 32'd0}) begin
                errors++;
                $display("FAIL reset: addr=%h ce=%b sreq=%b id_pc=%h id_inst=%h expected all zero",
                         inst_addr_o, inst_ce_o, stallreq_if_o, id_pc_o, id_inst_o);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({inst_addr_o, inst_ce_o, id_pc_o, id_inst_o} !== {m_pc, m_ce, m_id_pc, m_id_inst}) begin
                errors++;
                $display("FAIL startup[%0d]: addr=%h ce=%b id_pc=%h id_inst=%h expected %h %b %h %h",
                         i, inst_addr_o, inst_ce_o, id_pc_o, id_inst_o, m_pc, m_ce, m_id_pc, m_id_inst);
            end
        end
        checks++;
        if ({inst_addr_o, inst_ce_o, id_pc_o} !== {32'h8, 1'b1, 32'h4}) begin
            errors++;
            $display("FAIL startup_seq: addr=%h ce=%b id_pc=%h expected 00000008 1 00000004",
                     inst_addr_o, inst_ce_o, id_pc_o);
        end
    endtask

    task automatic test_wait();
        inst_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (stallreq_if_o !== 1'b1) begin
                errors++;
                $display("FAIL wait_sreq[%0d]: got %b expected 1", i, stallreq_if_o);
            end
            step();
            checks++;
            if ({inst_addr_o, id_pc_o, id_inst_o} !== {32'h8, 32'd0, 32'd0}) begin
                errors++;
                $display("FAIL wait_hold[%0d]: addr=%h id_pc=%h id_inst=%h expected 00000008 0 0",
                         i, inst_addr_o, id_pc_o, id_inst_o);
            end
        end
        inst_ready_i = 1'b1;
        step();
        checks++;
        if ({inst_addr_o, id_pc_o, id_inst_o, stallreq_if_o} !== {32'hC, 32'h8, rom(32'h8), 1'b0}) begin
            errors++;
            $display("FAIL wait_resume: addr=%h id_pc=%h id_inst=%h sreq=%b expected 0000000c 00000008 %h 0",
                     inst_addr_o, id_pc_o, id_inst_o, stallreq_if_o, rom(32'h8));
        end
    endtask

    task automatic test_branch();
        step();
        branch_flag_i = 1'b1; branch_target_i = 32'h100;
        step();
        branch_flag_i = 1'b0;
        checks++;
        if ({inst_addr_o, id_pc_o, id_inst_o} !== {32'h100, 32'h10, rom(32'h10)}) begin
            errors++;
            $display("FAIL branch_delay_slot: addr=%h id_pc=%h id_inst=%h expected 00000100 00000010 %h",
                     inst_addr_o, id_pc_o, id_inst_o, rom(32'h10));
        end
    endtask

    task automatic test_flush();
        flush_i = 1'b1; new_pc_i = 32'h20; branch_flag_i = 1'b1;
        branch_target_i = 32'h300; stall_i = 6'b000111;
        step();
        clear_inputs();
        checks++;
        if ({inst_addr_o, id_pc_o, id_inst_o} !== {32'h20, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL flush_priority: addr=%h id_pc=%h id_inst=%h expected 00000020 0 0",
                     inst_addr_o, id_pc_o, id_inst_o);
        end
    endtask

    task automatic test_stall();
        step();
        stall_i = 6'b000111;
        step();
        checks++;
        if ({inst_addr_o, id_pc_o, id_inst_o} !== {32'h24, 32'h20, rom(32'h20)}) begin
            errors++;
            $display("FAIL stall_hold: addr=%h id_pc=%h id_inst=%h expected 00000024 00000020 %h",
                     inst_addr_o, id_pc_o, id_inst_o, rom(32'h20));
        end
        stall_i = 6'b000011;
        step();
        stall_i = 6'd0;
        checks++;
        if ({inst_addr_o, id_pc_o, id_inst_o} !== {32'h24, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL stall_bubble: addr=%h id_pc=%h id_inst=%h expected 00000024 0 0",
                     inst_addr_o, id_pc_o, id_inst_o);
        end
    endtask

    task automatic test_wrap_align();
        flush_i = 1'b1; new_pc_i = 32'hFFFF_FFFF;
        step();
        clear_inputs();
        checks++;
        if (inst_addr_o !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL flush_align: got %h expected fffffffc", inst_addr_o);
        end
        step();
        checks++;
        if ({inst_addr_o, id_pc_o} !== {32'h0, 32'hFFFF_FFFC}) begin
            errors++;
            $display("FAIL pc_wrap: addr=%h id_pc=%h expected 00000000 fffffffc", inst_addr_o, id_pc_o);
        end
        branch_flag_i = 1'b1; branch_target_i = 32'h103;
        step();
        clear_inputs();
        checks++;
        if (inst_addr_o !== 32'h100) begin
            errors++;
            $display("FAIL branch_align: got %h expected 00000100", inst_addr_o);
        end
    endtask

    task automatic test_reset_mid_wait();
        inst_ready_i = 1'b0;
        step();
        rst = 1'b1;
        step();
        checks++;
        if ({inst_addr_o, inst_ce_o, stallreq_if_o, id_pc_o, id_inst_o} !== {32'd0, 1'b0, 1'b0, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset_mid_wait: addr=%h ce=%b sreq=%b id_pc=%h id_inst=%h expected all zero",
                     inst_addr_o, inst_ce_o, stallreq_if_o, id_pc_o, id_inst_o);
        end
        rst = 1'b0; inst_ready_i = 1'b1;
    endtask

    task automatic test_random();
        logic [5:0] stall_pick [0:7];
        logic       exp_sreq;
        stall_pick[0] = 6'b000000; stall_pick[1] = 6'b000000; stall_pick[2] = 6'b000001;
        stall_pick[3] = 6'b000011; stall_pick[4] = 6'b000111; stall_pick[5] = 6'b000010;
        stall_pick[6] = 6'b000110; stall_pick[7] = 6'b000100;
        for (int i = 0; i < 400; i++) begin
            rst             = ($urandom_range(0, 59) == 0);
            flush_i         = ($urandom_range(0, 19) == 0);
            new_pc_i        = $urandom;
            branch_flag_i   = ($urandom_range(0, 7) == 0);
            branch_target_i = $urandom;
            inst_ready_i    = ($urandom_range(0, 3) != 0);
            stall_i         = stall_pick[$urandom_range(0, 7)] | {3'($urandom_range(0, 7)), 3'b000};
            step();
            exp_sreq = m_ce & ~inst_ready_i & ~rst;
            checks++;
            if ({inst_addr_o, inst_ce_o, stallreq_if_o, id_pc_o, id_inst_o} !==
                {m_pc, m_ce, exp_sreq, m_id_pc, m_id_inst}) begin
                errors++;
                $display("FAIL random[%0d]: addr=%h ce=%b sreq=%b id_pc=%h id_inst=%h expected %h %b %b %h %h",
                         i, inst_addr_o, inst_ce_o, stallreq_if_o, id_pc_o, id_inst_o,
                         m_pc, m_ce, exp_sreq, m_id_pc, m_id_inst);
            end
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_wait();
        test_branch();
        test_flush();
        test_stall();
        test_wrap_align();
        test_reset_mid_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
